// File: rtl/plot_arbiter.sv
// Round-robin arbiter that walks one requester's solid rectangle at a time onto
// the single pixel-write port of the 160x120 VGA adapter.
module plot_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned XSCREEN = 160,
  parameter int unsigned YSCREEN = 120
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [7*NREQ-1:0] req_y,
  input  logic [4*NREQ-1:0] req_w,
  input  logic [4*NREQ-1:0] req_h,
  input  logic [3*NREQ-1:0] req_colour,
  input  logic              hold,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [7:0]        VGA_X,
  output logic [6:0]        VGA_Y,
  output logic [2:0]        VGA_COLOR,
  output logic              plot
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t          state_q;
  logic [IW-1:0]   rr_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [3:0]      w_q;
  logic [3:0]      h_q;
  logic [2:0]      col_q;
  logic [3:0]      xc_q;
  logic [3:0]      yc_q;

  logic [7:0] fx   [NREQ];
  logic [6:0] fy   [NREQ];
  logic [3:0] fw   [NREQ];
  logic [3:0] fh   [NREQ];
  logic [2:0] fcol [NREQ];

  logic [IW-1:0] cand;
  logic [IW-1:0] win_d;
  logic          win_valid_d;
  logic [IW-1:0] rr_d;

  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_screen;
  logic       fill;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      fx[i]   = req_x[8*i +: 8];
      fy[i]   = req_y[7*i +: 7];
      fw[i]   = req_w[4*i +: 4];
      fh[i]   = req_h[4*i +: 4];
      fcol[i] = req_colour[3*i +: 3];
    end
  end

  // First set request at or after rr, wrapping modulo NREQ.
  always_comb begin
    cand        = '0;
    win_d       = '0;
    win_valid_d = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(rr_q) + k) % NREQ);
      if (!win_valid_d && req[cand]) begin
        win_valid_d = 1'b1;
        win_d       = cand;
      end
    end
    rr_d = (win_d == IW'(NREQ - 1)) ? '0 : win_d + 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (win_valid_d) begin
            x_q     <= fx[win_d];
            y_q     <= fy[win_d];
            w_q     <= fw[win_d];
            h_q     <= fh[win_d];
            col_q   <= fcol[win_d];
            xc_q    <= '0;
            yc_q    <= '0;
            gnt_q   <= NREQ'(1) << win_d;
            rr_q    <= rr_d;
            state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (!hold) begin
            if (xc_q == w_q) begin
              xc_q <= '0;
              if (yc_q == h_q) begin
                done_q  <= gnt_q;
                state_q <= S_DONE;
              end else begin
                yc_q <= yc_q + 1'b1;
              end
            end else begin
              xc_q <= xc_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sums are one bit wider than the adapter ports so off-screen pixels clip.
  always_comb begin
    fill      = (state_q == S_FILL);
    sum_x     = {1'b0, x_q} + {5'b0, xc_q};
    sum_y     = {1'b0, y_q} + {4'b0, yc_q};
    in_screen = (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
    plot      = fill && in_screen && !hold;
    VGA_X     = fill ? sum_x[7:0] : '0;
    VGA_Y     = fill ? sum_y[6:0] : '0;
    VGA_COLOR = fill ? col_q : '0;
    busy      = (state_q != S_IDLE);
    gnt       = gnt_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: rectangle table plus scoreboard of
// expected pixels and done pulses, with hand sequences for hold/reset cases.
module tb_plot_arbiter;

  localparam int NREQ = 3;

  logic              Clock;
  logic              Resetn;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_x;
  logic [7*NREQ-1:0] req_y;
  logic [4*NREQ-1:0] req_w;
  logic [4*NREQ-1:0] req_h;
  logic [3*NREQ-1:0] req_colour;
  logic              hold;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        VGA_X;
  logic [6:0]        VGA_Y;
  logic [2:0]        VGA_COLOR;
  logic              plot;

  plot_arbiter #(.NREQ(NREQ), .XSCREEN(160), .YSCREEN(120)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .hold(hold),
    .gnt(gnt), .done(done), .busy(busy), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int r; int x; int y; int w; int h; int c; int fill; int plots;
  } vec_t;

  vec_t        tbl [6];
  logic [17:0] pq [$];
  int          dq [$];
  int          checks    = 0;
  int          failures  = 0;
  int          fill_cnt  = 0;
  int          plot_cnt  = 0;
  logic [NREQ-1:0] prev_done = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event/timeout, required none at %0t", name, $time);
  endtask

  // Advance one cycle and score whatever the DUT shows at the negedge.
  task automatic tick();
    logic [17:0] e;
    int r;
    @(negedge Clock);
    if (busy && done == '0) fill_cnt++;
    if (plot) begin
      plot_cnt++;
      if (pq.size() == 0) fail("unexpected_plot");
      else begin
        e = pq.pop_front();
        check("pixel", {14'd0, VGA_X, VGA_Y, VGA_COLOR}, {14'd0, e});
      end
    end
    if (done != '0) begin
      if (prev_done != '0) fail("done_width");
      if (dq.size() == 0) fail("unexpected_done");
      else begin
        r = dq.pop_front();
        check("done_idx", 32'(done), 32'(1 << r));
        check("gnt_at_done", 32'(gnt), 32'(1 << r));
      end
    end
    prev_done = done;
  endtask

  task automatic set_rect(input int r, input int x, input int y, input int w, input int h, input int c);
    req_x[8*r +: 8]      = 8'(x);
    req_y[7*r +: 7]      = 7'(y);
    req_w[4*r +: 4]      = 4'(w);
    req_h[4*r +: 4]      = 4'(h);
    req_colour[3*r +: 3] = 3'(c);
  endtask

  task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
    int px, py;
    for (int yy = 0; yy <= h; yy++)
      for (int xx = 0; xx <= w; xx++) begin
        px = x + xx;
        py = y + yy;
        if (px < 160 && py < 120) pq.push_back({8'(px), 7'(py), 3'(c)});
      end
  endtask

  task automatic check_idle(input string name);
    check({name, "_gnt"}, 32'(gnt), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_plot"}, 32'(plot), 0);
    check({name, "_xyc"}, {14'd0, VGA_X, VGA_Y, VGA_COLOR}, 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done == '0 && n < budget) begin
      tick();
      n++;
    end
    if (done == '0) fail("done_timeout");
  endtask

  task automatic run_rect(input vec_t v);
    int p0;
    p0 = plot_cnt;
    fill_cnt = 0;
    set_rect(v.r, v.x, v.y, v.w, v.h, v.c);
    push_rect(v.x, v.y, v.w, v.h, v.c);
    dq.push_back(v.r);
    req[v.r] = 1'b1;
    tick();
    check("grant_latency", 32'(gnt), 32'(1 << v.r));
    check("busy_latency", 32'(busy), 1);
    wait_done(600);
    req[v.r] = 1'b0;
    check("fill_cycles", fill_cnt, v.fill);
    check("plot_count", plot_cnt - p0, v.plots);
    tick();
    check_idle("idle_after_done");
    check("pending_pixels", pq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    #1 check_idle("reset");
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    int p0, n;
    Resetn = 1'b0; req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0;
    req_colour = '0; hold = 1'b0;
    tbl[0] = '{r:0, x:30,  y:30,  w:9,  h:9,  c:3'b100, fill:100, plots:100};
    tbl[1] = '{r:1, x:155, y:115, w:9,  h:9,  c:3'b011, fill:100, plots:25};
    tbl[2] = '{r:2, x:0,   y:0,   w:0,  h:0,  c:3'b111, fill:1,   plots:1};
    tbl[3] = '{r:0, x:0,   y:0,   w:15, h:15, c:3'b001, fill:256, plots:256};
    tbl[4] = '{r:1, x:159, y:119, w:1,  h:2,  c:3'b110, fill:6,   plots:1};
    tbl[5] = '{r:2, x:100, y:10,  w:4,  h:2,  c:3'b010, fill:15,  plots:15};

    #12 check_idle("por");
    @(negedge Clock);
    Resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_rect(tbl[i]);

    // Round robin with all three requests held continuously.
    do_reset();
    for (int r = 0; r < NREQ; r++) set_rect(r, r * 10, 5, 1, 1, r + 1);
    for (int k = 0; k < 6; k++) begin
      push_rect((k % 3) * 10, 5, 1, 1, (k % 3) + 1);
      dq.push_back(k % 3);
    end
    fill_cnt = 0;
    req = '1;
    n = 0;
    while (dq.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (dq.size() != 0) fail("rr_timeout");
    req = '0;
    check("rr_fill_cycles", fill_cnt, 24);
    tick();
    check_idle("rr_idle");
    check("rr_pending", pq.size(), 0);

    // Hold during the second pixel of a 4x1 rectangle.
    p0 = plot_cnt;
    fill_cnt = 0;
    set_rect(0, 10, 20, 3, 0, 3'b010);
    push_rect(10, 20, 3, 0, 3'b010);
    dq.push_back(0);
    req[0] = 1'b1;
    tick();
    @(posedge Clock);
    #1 hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_plot", 32'(plot), 0);
      check("hold_x", 32'(VGA_X), 11);
    end
    @(posedge Clock);
    #1 hold = 1'b0;
    wait_done(50);
    req[0] = 1'b0;
    check("hold_fill_cycles", fill_cnt, 7);
    check("hold_plots", plot_cnt - p0, 4);
    tick();
    check_idle("hold_idle");

    // Inputs change mid-rectangle; latched values must be used.
    p0 = plot_cnt;
    set_rect(2, 60, 40, 3, 3, 3'b101);
    push_rect(60, 40, 3, 3, 3'b101);
    dq.push_back(2);
    req[2] = 1'b1;
    tick();
    tick();
    tick();
    set_rect(2, 0, 0, 0, 0, 3'b001);
    wait_done(50);
    req[2] = 1'b0;
    check("latch_plots", plot_cnt - p0, 16);
    tick();
    check_idle("latch_idle");

    // Asynchronous reset while pixel 5 of a 10x10 rectangle is showing.
    set_rect(0, 50, 50, 9, 9, 3'b110);
    for (int k = 0; k < 5; k++) pq.push_back({8'(50 + k), 7'd50, 3'b110});
    req[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    @(posedge Clock);
    #1 Resetn = 1'b0;
    #1;
    check("rst_plot", 32'(plot), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    req[0] = 1'b0;
    req[1] = 1'b1;
    set_rect(1, 20, 20, 1, 1, 3'b011);
    push_rect(20, 20, 1, 1, 3'b011);
    dq.push_back(1);
    tick();
    check("rst_no_done", 32'(done), 0);
    Resetn = 1'b1;
    tick();
    check("rst_regrant", 32'(gnt), 32'b010);
    wait_done(50);
    req[1] = 1'b0;
    tick();
    check_idle("rst_idle");
    check("final_pending", pq.size() + dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single pixel-write port of the 160x120 VGA adapter among NREQ rectangle-drawing requesters (e.g. snake body, apple, erase). Each requester asks for a solid filled rectangle (origin, size, colour). The arbiter grants one requester at a time in round-robin order and walks that rectangle pixel by pixel onto the adapter's x/y/colour/plot inputs. When the rectangle is finished it returns a one-cycle done pulse to the requester. It sits between the game FSMs and vga_adapter, and replaces per-FSM muxing of the adapter inputs.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8); requester 0 has the lowest index.
- XSCREEN, 160, horizontal pixel limit for clipping.
- YSCREEN, 120, vertical pixel limit for clipping.

Ports:
- Clock  in  1  system clock (CLOCK_50 domain); one clock only.
- Resetn  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; hold high until the matching done.
- req_x  in  8*NREQ  rectangle left x, field i = bits [8i+7:8i].
- req_y  in  7*NREQ  rectangle top y, field i = bits [7i+6:7i].
- req_w  in  4*NREQ  width minus 1 (0..15 encodes 1..16 pixels).
- req_h  in  4*NREQ  height minus 1 (0..15 encodes 1..16 pixels).
- req_colour  in  3*NREQ  3-bit RGB fill colour.
- hold  in  1  stall: while high in FILL, the pixel counters freeze and plot=0.
- gnt  out  NREQ  one-hot grant to the requester being served.
- done  out  NREQ  one-cycle pulse when that requester's rectangle is complete.
- busy  out  1  high in FILL and DONE.
- VGA_X  out  8  pixel x to the adapter.
- VGA_Y  out  7  pixel y to the adapter.
- VGA_COLOR  out  3  pixel colour to the adapter.
- plot  out  1  write strobe to the adapter.

## Operation
- States are IDLE, FILL and DONE.
- IDLE: if any req bit is high, the winner is the first set bit at or after pointer rr, searching upward and wrapping modulo NREQ. On the clock edge that leaves IDLE:
  - latch the winner's x, y, w, h and colour;
  - clear xc and yc;
  - set gnt to the winner's one-hot bit;
  - set rr to winner+1 mod NREQ;
  - go to FILL.
- IDLE with no request: stay in IDLE; all outputs at their idle values.
- FILL: the current pixel is (x+xc, y+yc) with the latched colour.
  - If hold=0, each edge increments xc.
  - When xc==w, xc clears and yc increments.
  - When xc==w and yc==h (last pixel), go to DONE on that edge.
  - If hold=1, the counters and state freeze and plot=0.
- Clipping: x+xc is computed 9 bits wide and y+yc 8 bits wide.
  - If x+xc >= XSCREEN or y+yc >= YSCREEN, plot=0 for that pixel. The cycle is still consumed.
  - VGA_X and VGA_Y carry the low 8 and 7 bits of those sums.
- DONE: done[winner]=1 for exactly this cycle and gnt is still held. The next edge goes to IDLE and clears gnt.
- Latched parameters are immune to input changes during FILL. Dropping req mid-FILL does not abort the rectangle.
- A requester still asserting req in IDLE after its done is served again, but only after every other pending requester (round-robin).
- Outputs in IDLE/DONE: plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0.

## Timing
- Reset (asynchronous, any state, including mid-FILL): state=IDLE, rr=0, gnt=0, done=0, busy=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0, xc=yc=0. An interrupted rectangle is abandoned with no done pulse.
- All outputs are decoded from registers; there are no combinational paths from inputs to outputs except hold→plot.
- Latency: req sampled high at edge E0 → gnt, busy and the first pixel (x, y) with plot=1 are visible in the cycle after E0.
- A rectangle of (w+1)(h+1) pixels with hold=0 occupies exactly (w+1)(h+1) FILL cycles, then 1 DONE cycle, then 1 IDLE cycle.
- Back-to-back grants to different requesters are separated by 2 non-plot cycles (DONE, IDLE).
- Pixel order is row-major: x increments fastest, rows go top to bottom.
- hold asserted for k cycles extends FILL by exactly k cycles; no pixel is skipped or repeated with plot=1.

## Test plan
- Single request: req[0]=1, x=30, y=30, w=h=9, colour=3'b100 → 100 plot cycles covering (30..39, 30..39) in row-major order, all colour 100; then done[0] pulses once; busy is low 2 cycles after the last pixel.
- Round-robin: req=3'b111 held continuously, each requester a 2x2 rectangle → grant order 0,1,2,0,1,2; each done is a single cycle with gnt still set.
- Clipping: x=155, y=115, w=h=9 → 100 FILL cycles; plot=1 only for x 155..159 and y 115..119 (25 pixels); done after cycle 100.
- Hold: a 4x1 rectangle with hold=1 during the second pixel for 3 cycles → pixel 1 output continuously with plot=0 for 3 cycles, then plot=1; total FILL = 7 cycles; 4 distinct plotted pixels.
- Mid-FILL reset: assert Resetn=0 asynchronously during pixel 5 of a 10x10 rectangle → plot, gnt and busy go 0 immediately with no done pulse; after release, a pending req[1] is granted ahead of req[0], because rr has reset to 0 and only req[1] is high.
- Input change during FILL: change req_x[0] and req_colour[0] mid-rectangle → the plotted pixels keep the originally latched origin and colour.
